// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared types, default panel timing and colour-bar table for the LCD timing block
package lcd_timing_pkg;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } lcd_state_t;

   localparam int DEF_H_SYNC   = 1;
   localparam int DEF_H_BP     = 182;
   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 210;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 6;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 45;

   localparam logic [15:0] DEF_UF_COLOR = 16'hF800;

   function automatic rgb565_t bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = 16'hFFFF;
         3'd1:    bar_color = 16'hFFE0;
         3'd2:    bar_color = 16'h07FF;
         3'd3:    bar_color = 16'h07E0;
         3'd4:    bar_color = 16'hF81F;
         3'd5:    bar_color = 16'hF800;
         3'd6:    bar_color = 16'h001F;
         default: bar_color = 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/lcd_timing_ctrl_if.sv
// rtl/lcd_timing_ctrl_if.sv - show-ahead pixel source handshake between the timing controller and the frame source
interface lcd_timing_ctrl_if;
   logic        pix_req;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_data;
   logic        pix_valid;

   modport master (
      output pix_req,
      output pix_x,
      output pix_y,
      input  pix_data,
      input  pix_valid
   );

   modport slave (
      input  pix_req,
      input  pix_x,
      input  pix_y,
      output pix_data,
      output pix_valid
   );
endinterface

// File: rtl/lcd_color_bar_gen.sv
// rtl/lcd_color_bar_gen.sv - eight vertical colour bars, bar index tracked by a pixel counter instead of a divider
module lcd_color_bar_gen
   import lcd_timing_pkg::*;
#(
   parameter int BAR_W = 100
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    act,
   input  logic    line_start,
   input  logic    enable,
   output rgb565_t rgb
);

   localparam int CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cur_cnt;
   logic [2:0]    idx;
   logic [2:0]    cur_idx;

   // line_start forces bar 0 in the same cycle so the first pixel of every line is correct
   always_comb begin
      cur_cnt = line_start ? '0 : cnt;
      cur_idx = line_start ? '0 : idx;
      rgb     = (act && enable) ? bar_color(cur_idx) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (act && enable) begin
         if (cur_cnt == CW'(BAR_W - 1)) begin
            cnt <= '0;
            idx <= cur_idx + 3'd1;
         end else begin
            cnt <= cur_cnt + 1'b1;
            idx <= cur_idx;
         end
      end
   end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// rtl/lcd_timing_ctrl.sv - RGB565 panel timing: H/V counters, sync/DEN generation, pixel fetch and registered pin drive
module lcd_timing_ctrl
   import lcd_timing_pkg::*;
#(
   parameter int          H_SYNC   = DEF_H_SYNC,
   parameter int          H_BP     = DEF_H_BP,
   parameter int          H_ACTIVE = DEF_H_ACTIVE,
   parameter int          H_FP     = DEF_H_FP,
   parameter int          V_SYNC   = DEF_V_SYNC,
   parameter int          V_BP     = DEF_V_BP,
   parameter int          V_ACTIVE = DEF_V_ACTIVE,
   parameter int          V_FP     = DEF_V_FP,
   parameter bit          SYNC_POL = 1'b0,
   parameter logic [15:0] UF_COLOR = DEF_UF_COLOR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              tpg,
   input  logic              uf_clr,
   lcd_timing_ctrl_if.master pix,
   output logic              lcd_pclk,
   output logic              lcd_hync,
   output logic              lcd_sync,
   output logic              lcd_den,
   output logic [4:0]        lcd_r,
   output logic [5:0]        lcd_g,
   output logic [4:0]        lcd_b,
   output logic              frame_start,
   output logic              underflow
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_START = H_SYNC + H_BP;
   localparam int V_START = V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);

   lcd_state_t     state, state_nxt;
   logic [H_W-1:0] h, h_nxt;
   logic [V_W-1:0] v, v_nxt;
   logic           run, h_last, v_last;
   logic           hs_a, vs_a, act, line_start;
   logic           tpg_q;
   rgb565_t        bar_rgb, pix_rgb, rgb_q;

   assign lcd_pclk = clk;
   assign run      = (state == ST_RUN);
   assign h_last   = (h == H_W'(H_TOTAL - 1));
   assign v_last   = (v == V_W'(V_TOTAL - 1));

   always_comb begin
      state_nxt = state;
      h_nxt     = h;
      v_nxt     = v;
      case (state)
         ST_IDLE: begin
            h_nxt = '0;
            v_nxt = '0;
            if (en) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (h_last) begin
               h_nxt = '0;
               if (v_last) begin
                  v_nxt = '0;
                  // stop only on the last pixel of a frame so a frame is never torn
                  if (!en) state_nxt = ST_IDLE;
               end else begin
                  v_nxt = v + 1'b1;
               end
            end else begin
               h_nxt = h + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         h     <= '0;
         v     <= '0;
         tpg_q <= 1'b0;
      end else begin
         state <= state_nxt;
         h     <= h_nxt;
         v     <= v_nxt;
         if (frame_start) tpg_q <= tpg;
      end
   end

   assign hs_a = run && (h < H_W'(H_SYNC));
   assign vs_a = run && (v < V_W'(V_SYNC));
   assign act  = run && (h >= H_W'(H_START)) && (h < H_W'(H_START + H_ACTIVE))
                     && (v >= V_W'(V_START)) && (v < V_W'(V_START + V_ACTIVE));
   assign line_start  = act && (h == H_W'(H_START));
   assign frame_start = run && (h == '0) && (v == '0);

   assign pix.pix_req = act && !tpg_q;
   assign pix.pix_x   = pix.pix_req ? 10'(h - H_W'(H_START)) : '0;
   assign pix.pix_y   = pix.pix_req ? 9'(v - V_W'(V_START)) : '0;

   lcd_color_bar_gen #(
      .BAR_W (H_ACTIVE / 8)
   ) u_bar (
      .clk        (clk),
      .rst        (rst),
      .act        (act),
      .line_start (line_start),
      .enable     (tpg_q),
      .rgb        (bar_rgb)
   );

   always_comb begin
      pix_rgb = '0;
      if (act) begin
         if (tpg_q)              pix_rgb = bar_rgb;
         else if (pix.pix_valid) pix_rgb = pix.pix_data;
         else                    pix_rgb = UF_COLOR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcd_hync  <= ~SYNC_POL;
         lcd_sync  <= ~SYNC_POL;
         lcd_den   <= 1'b0;
         rgb_q     <= '0;
         underflow <= 1'b0;
      end else begin
         lcd_hync <= hs_a ? SYNC_POL : ~SYNC_POL;
         lcd_sync <= vs_a ? SYNC_POL : ~SYNC_POL;
         lcd_den  <= act;
         rgb_q    <= pix_rgb;
         if (pix.pix_req && !pix.pix_valid) underflow <= 1'b1;
         else if (uf_clr)                   underflow <= 1'b0;
      end
   end

   assign lcd_r = rgb_q.r;
   assign lcd_g = rgb_q.g;
   assign lcd_b = rgb_q.b;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb/tb_lcd_timing_ctrl.sv - randomized bench for lcd_timing_ctrl against a frame-position reference model
module tb_lcd_timing_ctrl;

   localparam int HSY = 2, HBP = 3, HAC = 16, HFP = 4;
   localparam int VSY = 2, VBP = 2, VAC = 6,  VFP = 2;
   localparam int HT  = HSY + HBP + HAC + HFP;
   localparam int VT  = VSY + VBP + VAC + VFP;
   localparam int FR  = HT * VT;
   localparam int HST = HSY + HBP;
   localparam int VST = VSY + VBP;
   localparam int BAR = HAC / 8;
   localparam logic [15:0] UF = 16'hF800;

   logic        clk = 1'b0;
   logic        rst, en, tpg, uf_clr;
   logic        lcd_pclk, lcd_hync, lcd_sync, lcd_den, frame_start, underflow;
   logic [4:0]  lcd_r, lcd_b;
   logic [5:0]  lcd_g;

   lcd_timing_ctrl_if pix_bus();

   lcd_timing_ctrl #(
      .H_SYNC(HSY), .H_BP(HBP), .H_ACTIVE(HAC), .H_FP(HFP),
      .V_SYNC(VSY), .V_BP(VBP), .V_ACTIVE(VAC), .V_FP(VFP),
      .SYNC_POL(1'b0), .UF_COLOR(UF)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .tpg(tpg), .uf_clr(uf_clr),
      .pix(pix_bus),
      .lcd_pclk(lcd_pclk), .lcd_hync(lcd_hync), .lcd_sync(lcd_sync), .lcd_den(lcd_den),
      .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
      .frame_start(frame_start), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   // reference state: running flag and linear position within the frame
   bit          m_run, m_tpg, m_uf;
   int          m_n;
   logic        e_hs, e_vs, e_den;
   logic [15:0] e_rgb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic decode(output int h, output int v, output bit act, output bit req, output bit fs);
      h   = m_n % HT;
      v   = m_n / HT;
      act = m_run && h >= HST && h < HST + HAC && v >= VST && v < VST + VAC;
      req = act && !m_tpg;
      fs  = m_run && m_n == 0;
   endtask

   task automatic check_cycle();
      int h, v;
      bit act, req, fs;
      decode(h, v, act, req, fs);
      chk("pix_req",     32'(pix_bus.pix_req), 32'(req));
      chk("pix_x",       32'(pix_bus.pix_x),   req ? 32'(h - HST) : 32'd0);
      chk("pix_y",       32'(pix_bus.pix_y),   req ? 32'(v - VST) : 32'd0);
      chk("frame_start", 32'(frame_start),     32'(fs));
      chk("hync",        32'(lcd_hync),        32'(e_hs));
      chk("sync",        32'(lcd_sync),        32'(e_vs));
      chk("den",         32'(lcd_den),         32'(e_den));
      chk("rgb",         32'({lcd_r, lcd_g, lcd_b}), 32'(e_rgb));
      chk("underflow",   32'(underflow),       32'(m_uf));
   endtask

   task automatic model_reset();
      m_run = 0; m_tpg = 0; m_uf = 0; m_n = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_den = 1'b0; e_rgb = '0;
   endtask

   // drive inputs for the next rising edge and advance the model across it
   task automatic step(input int c);
      int h, v;
      bit act, req, fs;
      decode(h, v, act, req, fs);
      en = (c >= 1000 && c < 1400) ? 1'b0 : ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 99) == 0) tpg = ~tpg;
      uf_clr = ($urandom_range(0, 4) == 0);
      pix_bus.pix_valid = ($urandom_range(0, 19) != 0);
      pix_bus.pix_data  = 16'($urandom);

      e_hs  = !(m_run && h < HSY);
      e_vs  = !(m_run && v < VSY);
      e_den = act;
      if (!act)                   e_rgb = '0;
      else if (m_tpg)             e_rgb = bar_tab[(h - HST) / BAR];
      else if (pix_bus.pix_valid) e_rgb = pix_bus.pix_data;
      else                        e_rgb = UF;

      if (req && !pix_bus.pix_valid) m_uf = 1;
      else if (uf_clr)               m_uf = 0;
      if (fs) m_tpg = tpg;

      if (!m_run) begin
         if (en) begin
            m_run = 1;
            m_n   = 0;
         end
      end else if (m_n == FR - 1) begin
         m_n = 0;
         if (!en) m_run = 0;
      end else begin
         m_n++;
      end
      @(negedge clk);
   endtask

   initial begin
      bit found;
      rst = 1'b1; en = 1'b1; tpg = 1'b0; uf_clr = 1'b0;
      pix_bus.pix_data = '0; pix_bus.pix_valid = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_cycle();
      rst = 1'b0;

      for (int c = 0; c < 2400; c++) begin
         step(c);
         check_cycle();
      end

      found = 0;
      for (int k = 0; k < 2 * FR && !found; k++) begin
         step(2400 + k);
         check_cycle();
         if (e_den) found = 1;
      end
      chk("den_seen", 32'(found), 32'd1);
      chk("pre_den", 32'(lcd_den), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_den", 32'(lcd_den), 32'd0);
      chk("async_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
      chk("async_req", 32'(pix_bus.pix_req), 32'd0);
      chk("async_uf",  32'(underflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
